vga_src_switch: RTL and testbench
=================================

# vga_src_switch

Parametrised N-source VGA output selector with frame-synchronous switching, configurable blank-frame transition and colour-key overlay. It sits between the per-screen renderers (menu, game, future screens) and the board pins, replacing fixed two-way muxing. Source changes requested mid-frame never tear: the switch takes effect only at a vsync rising edge, optionally preceded by black frames.

## Interface
- N_SRC, 4: number of VGA sources, 2..8
- RGB_W, 12: packed rgb width (4:4:4)
- BLANK_FRAMES, 1: full black frames inserted on each switch, 0..15
- KEY_COLOR, 12'hF0F: transparent colour for overlay mode
- clk  in  1  pixel clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- in_hsync, in_vsync, in_hblnk, in_vblnk  in  N_SRC each  per-source timing (all sources aligned; only index 0 used for timing)
- in_rgb  in  N_SRC×RGB_W  per-source pixel
- req_valid  in  1  one-cycle request strobe
- req_src  in  $clog2(N_SRC)  requested source index
- ovl_en  in  1  overlay enable (level)
- out_hsync, out_vsync, out_hblnk, out_vblnk  out  1  source-0 timing delayed 1 cycle
- out_rgb  out  RGB_W  selected/composited pixel, registered
- cur_src  out  $clog2(N_SRC)  source currently driving the output
- busy  out  1  high in WAIT_VS and BLANK

## Operation
- FSM states: SHOW, WAIT_VS, BLANK. Reset: SHOW, cur_src=0, pend_src=0, cnt=0, all outputs 0.
- Frame edge: vs_edge = in_vsync[0] & ~vs_q (vs_q = registered in_vsync[0]).
- Request accept: req_valid with req_src < N_SRC → pend_src <= req_src, pend_flag <= 1. req_src ≥ N_SRC is ignored. In SHOW, a request equal to cur_src with no pending request is ignored.
- SHOW: pend_flag → WAIT_VS (next cycle).
- WAIT_VS: on vs_edge, cur_src <= pend_src, pend_flag <= 0; BLANK_FRAMES==0 → SHOW, else → BLANK with cnt=BLANK_FRAMES.
- BLANK: on vs_edge, cnt--; on the edge where cnt==1 → SHOW (exactly BLANK_FRAMES frames black).
- Request in WAIT_VS/BLANK: overwrites pend_src (latest wins); if set after the WAIT_VS edge, FSM returns to WAIT_VS from SHOW for a second switch.
- Request and vs_edge in same cycle while in SHOW: the switch occurs at the following vs_edge, not this one.
- Pixel: pix = in_rgb[cur_src]; if ovl_en and cur_src≠0 and pix==KEY_COLOR → pix = in_rgb[0].
- out_rgb = 0 when in_hblnk[0] | in_vblnk[0], or state==BLANK, or (state==WAIT_VS is not blanked; old source continues); else pix.

## Timing
- Latency 1 cycle for all out_* relative to source 0 inputs; out_rgb and out timing are mutually aligned.
- cur_src updates on the clock edge following the vs_edge cycle; the first pixel from the new source appears at the output 1 cycle later (BLANK_FRAMES==0).
- busy asserted the cycle after an accepted request in SHOW; deasserted when returning to SHOW.
- Reset assertion at any point returns immediately (asynchronously) to reset values; pending requests are discarded.

## Structure
- vga_pkg: state enum type (SHOW/WAIT_VS/BLANK), default KEY_COLOR, RGB width constant.
- Sub-module vga_frame_edge: registers vsync and produces vs_edge; reused by later frame-synchronous blocks.
- Top-level gameplay instantiates this block with N_SRC=2 (menu, game); menu state drives req_valid/req_src.

## Test plan
- Reset: hold rst=0 mid-frame → all outputs 0, cur_src=0, busy=0; release → source 0 pixels appear 1 cycle after input.
- Switch 0→2, BLANK_FRAMES=1, request at line 100 → old source until vsync edge, then exactly one black frame, source 2 from the next frame; busy high throughout.
- BLANK_FRAMES=0, request coinciding with vs_edge → switch deferred a full frame; cur_src changes on the following edge.
- Requests 1 then 3 within one frame, then req_src=5 (N_SRC=4) → only 3 applied, 5 ignored, single transition.
- Overlay: cur_src=1, ovl_en=1, in_rgb[1]=12'hF0F, in_rgb[0]=12'h123 → out_rgb=12'h123; ovl_en=0 → 12'hF0F.
- Blanking: in_hblnk[0]=1 with nonzero pixels → out_rgb=0 one cycle later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA source-switching blocks.
package vga_pkg;

    typedef enum logic [1:0] {
        StShow,
        StWaitVs,
        StBlank
    } vga_state_e;

    localparam int unsigned VgaRgbW = 12;
    localparam logic [VgaRgbW-1:0] VgaKeyColor = 12'hF0F;

endpackage

// File: rtl/vga_frame_edge.sv
// Registers vsync and flags its rising edge, the frame boundary for frame-synchronous logic.
module vga_frame_edge (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic vs_edge
);

    logic vs_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vsync;
        end
    end

    assign vs_edge = vsync & ~vs_q;

endmodule

// File: rtl/vga_src_switch.sv
// N-source VGA output selector: tear-free source changes at vsync, optional black frames,
// and colour-key overlay of the selected source over source 0.
module vga_src_switch
    import vga_pkg::*;
#(
    parameter int unsigned      N_SRC        = 4,
    parameter int unsigned      RGB_W        = VgaRgbW,
    parameter int unsigned      BLANK_FRAMES = 1,
    parameter logic [RGB_W-1:0] KEY_COLOR    = RGB_W'(VgaKeyColor)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SRC-1:0]           in_hsync,
    input  logic [N_SRC-1:0]           in_vsync,
    input  logic [N_SRC-1:0]           in_hblnk,
    input  logic [N_SRC-1:0]           in_vblnk,
    input  logic [N_SRC*RGB_W-1:0]     in_rgb,
    input  logic                       req_valid,
    input  logic [$clog2(N_SRC)-1:0]   req_src,
    input  logic                       ovl_en,
    output logic                       out_hsync,
    output logic                       out_vsync,
    output logic                       out_hblnk,
    output logic                       out_vblnk,
    output logic [RGB_W-1:0]           out_rgb,
    output logic [$clog2(N_SRC)-1:0]   cur_src,
    output logic                       busy
);

    localparam int unsigned SrcW = $clog2(N_SRC);

    vga_state_e       state_q, state_d;
    logic [SrcW-1:0]  cur_src_q, cur_src_d;
    logic [SrcW-1:0]  pend_src_q, pend_src_d;
    logic             pend_flag_q, pend_flag_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       timing_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             vs_edge;
    logic             req_ok;
    logic [RGB_W-1:0] pix;
    logic [RGB_W-1:0] src_rgb [N_SRC];

    // Only source 0 supplies timing; the other sources' timing is aligned by contract.
    logic unused_timing;
    assign unused_timing = ^{in_hsync[N_SRC-1:1], in_vsync[N_SRC-1:1],
                             in_hblnk[N_SRC-1:1], in_vblnk[N_SRC-1:1]};

    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_rgb[i] = in_rgb[i*RGB_W +: RGB_W];
    end

    vga_frame_edge u_frame_edge (
        .clk     (clk),
        .rst     (rst),
        .vsync   (in_vsync[0]),
        .vs_edge (vs_edge)
    );

    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        pend_src_d  = pend_src_q;
        pend_flag_d = pend_flag_q;
        cnt_d       = cnt_q;
        req_ok      = req_valid && (32'(req_src) < N_SRC);
        if (state_q == StShow && !pend_flag_q && req_src == cur_src_q) begin
            req_ok = 1'b0;
        end

        unique case (state_q)
            StShow: begin
                if (pend_flag_q || req_ok) begin
                    state_d = StWaitVs;
                end
            end
            StWaitVs: begin
                if (vs_edge) begin
                    cur_src_d   = pend_src_q;
                    pend_flag_d = 1'b0;
                    if (BLANK_FRAMES == 0) begin
                        state_d = StShow;
                    end else begin
                        state_d = StBlank;
                        cnt_d   = 4'(BLANK_FRAMES);
                    end
                end
            end
            StBlank: begin
                if (vs_edge) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = StShow;
                    end
                end
            end
            default: state_d = StShow;
        endcase

        // A request landing on the switching edge survives as the next pending switch.
        if (req_ok) begin
            pend_src_d  = req_src;
            pend_flag_d = 1'b1;
        end
    end

    always_comb begin
        pix = src_rgb[cur_src_q];
        if (ovl_en && cur_src_q != '0 && pix == KEY_COLOR) begin
            pix = src_rgb[0];
        end
        rgb_d = pix;
        if (in_hblnk[0] || in_vblnk[0] || state_q == StBlank) begin
            rgb_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StShow;
            cur_src_q   <= '0;
            pend_src_q  <= '0;
            pend_flag_q <= 1'b0;
            cnt_q       <= '0;
            timing_q    <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            pend_src_q  <= pend_src_d;
            pend_flag_q <= pend_flag_d;
            cnt_q       <= cnt_d;
            timing_q    <= {in_hsync[0], in_vsync[0], in_hblnk[0], in_vblnk[0]};
            rgb_q       <= rgb_d;
        end
    end

    assign {out_hsync, out_vsync, out_hblnk, out_vblnk} = timing_q;
    assign out_rgb = rgb_q;
    assign cur_src = cur_src_q;
    assign busy    = (state_q != StShow);

endmodule

// File: tb/tb_vga_src_switch.sv
// Bench for vga_src_switch: two instances (1 and 0 blank frames) on a shared miniature raster.
module tb_vga_src_switch;

    localparam int unsigned N    = 5;
    localparam int unsigned W    = 12;
    localparam int          HTOT = 16;
    localparam int          VTOT = 10;
    localparam logic [W-1:0] KEY = 12'hF0F;

    logic           clk, rst;
    logic [N-1:0]   in_hsync, in_vsync, in_hblnk, in_vblnk;
    logic [N*W-1:0] in_rgb;
    logic           req_valid, ovl_en;
    logic [2:0]     req_src;

    logic           hs_a, vs_a, hb_a, vb_a, busy_a;
    logic           hs_b, vs_b, hb_b, vb_b, busy_b;
    logic [W-1:0]   rgb_a, rgb_b;
    logic [2:0]     cur_a, cur_b;

    int n_total = 0;
    int n_pass  = 0;
    int hcnt = 0, vcnt = 0;
    bit rand_pix = 0;
    bit chk_en = 0;

    vga_src_switch #(.N_SRC(N), .RGB_W(W), .BLANK_FRAMES(1), .KEY_COLOR(KEY)) dut_a (
        .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk),
        .in_vblnk(in_vblnk), .in_rgb(in_rgb), .req_valid(req_valid), .req_src(req_src),
        .ovl_en(ovl_en), .out_hsync(hs_a), .out_vsync(vs_a), .out_hblnk(hb_a),
        .out_vblnk(vb_a), .out_rgb(rgb_a), .cur_src(cur_a), .busy(busy_a)
    );

    vga_src_switch #(.N_SRC(N), .RGB_W(W), .BLANK_FRAMES(0), .KEY_COLOR(KEY)) dut_b (
        .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk),
        .in_vblnk(in_vblnk), .in_rgb(in_rgb), .req_valid(req_valid), .req_src(req_src),
        .ovl_en(ovl_en), .out_hsync(hs_b), .out_vsync(vs_b), .out_hblnk(hb_b),
        .out_vblnk(vb_b), .out_rgb(rgb_b), .cur_src(cur_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [W-1:0] src_pix(int s);
        return in_rgb[s*W +: W];
    endfunction

    task automatic set_pix(int s, logic [W-1:0] v);
        in_rgb[s*W +: W] = v;
    endtask

    task automatic drive_timing();
        in_hsync = (hcnt >= 13 && hcnt <= 14) ? '1 : '0;
        in_vsync = (vcnt == VTOT - 1) ? '1 : '0;
        in_hblnk = (hcnt >= 12) ? '1 : '0;
        in_vblnk = (vcnt >= 8) ? '1 : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        hcnt++;
        if (hcnt == HTOT) begin
            hcnt = 0;
            vcnt = (vcnt + 1) % VTOT;
        end
        drive_timing();
        if (rand_pix) begin
            for (int s = 0; s < N; s++) set_pix(s, ($urandom_range(0, 3) == 0) ? KEY : W'($urandom));
        end
    endtask

    task automatic goto(int v, int h);
        for (int i = 0; i < 400; i++) begin
            if (vcnt == v && hcnt == h) return;
            tick();
        end
        n_total++;
        $display("FAIL goto_timeout: raster never reached line %0d pixel %0d", v, h);
    endtask

    task automatic request(int s);
        req_valid = 1'b1;
        req_src   = 3'(s);
    endtask

    // Reference model: per instance, the shown source, the latest pending request (-1 = none),
    // whether a switch is waiting for the next frame start, and black frames still to show.
    int          m_cur [2], m_pend [2], m_blk [2];
    bit          m_wait [2];
    int          m_bf [2] = '{1, 0};
    bit          m_prev_vs;
    logic [W-1:0] e_rgb [2];
    logic [3:0]  e_tim;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_prev_vs = 1'b0;
                e_tim = '0;
                for (int k = 0; k < 2; k++) begin
                    m_cur[k] = 0; m_pend[k] = -1; m_blk[k] = 0; m_wait[k] = 1'b0;
                    e_rgb[k] = '0;
                end
            end else begin
                bit frame_start;
                frame_start = in_vsync[0] && !m_prev_vs;
                m_prev_vs   = in_vsync[0];
                e_tim = {in_hsync[0], in_vsync[0], in_hblnk[0], in_vblnk[0]};
                for (int k = 0; k < 2; k++) begin
                    logic [W-1:0] p;
                    bit shown, accept;
                    p = src_pix(m_cur[k]);
                    if (ovl_en && m_cur[k] != 0 && p == KEY) p = src_pix(0);
                    e_rgb[k] = (in_hblnk[0] || in_vblnk[0] || m_blk[k] > 0) ? '0 : p;
                    shown  = !m_wait[k] && m_blk[k] == 0;
                    accept = req_valid && int'(req_src) < N &&
                             !(shown && m_pend[k] < 0 && int'(req_src) == m_cur[k]);
                    if (shown) begin
                        if (m_pend[k] >= 0 || accept) m_wait[k] = 1'b1;
                    end else if (m_wait[k]) begin
                        if (frame_start) begin
                            m_cur[k]  = m_pend[k];
                            m_pend[k] = -1;
                            m_wait[k] = 1'b0;
                            m_blk[k]  = m_bf[k];
                        end
                    end else if (frame_start) begin
                        m_blk[k]--;
                    end
                    if (accept) m_pend[k] = int'(req_src);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model_a", {hs_a, vs_a, hb_a, vb_a, busy_a, cur_a, rgb_a},
                      {e_tim, (m_wait[0] || m_blk[0] > 0), 3'(m_cur[0]), e_rgb[0]});
                check("model_b", {hs_b, vs_b, hb_b, vb_b, busy_b, cur_b, rgb_b},
                      {e_tim, (m_wait[1] || m_blk[1] > 0), 3'(m_cur[1]), e_rgb[1]});
            end
        end
    end

    initial begin
        rst = 1'b0; ovl_en = 1'b0; req_valid = 1'b0; req_src = '0;
        for (int s = 0; s < N; s++) set_pix(s, W'(12'h0A0 + s));
        drive_timing();
        tick();
        chk_en = 1'b1;
        tick(); tick();
        rst = 1'b1;

        // Source 0 visible one cycle after input.
        goto(2, 3); set_pix(0, 12'h5A5); tick();
        check("t1_src0_a", rgb_a, 12'h5A5);
        check("t1_src0_b", rgb_b, 12'h5A5);
        check("t1_cur_busy_a", {cur_a, busy_a}, 4'b0000);

        // Switch 0->2: old source until the edge, then one black frame on instance a.
        goto(4, 0); request(2); tick();
        check("t2_busy_a", busy_a, 1'b1);
        set_pix(0, 12'h111); set_pix(2, 12'h222);
        goto(5, 2); tick();
        check("t2_old_src_a", rgb_a, 12'h111);
        goto(9, 0); tick();
        check("t2_cur_a", cur_a, 3'd2);
        check("t2_blank_busy_a", busy_a, 1'b1);
        check("t2_busy_b", busy_b, 1'b0);
        goto(0, 0); tick();
        check("t2_black_a", rgb_a, 12'h000);
        check("t2_new_b", rgb_b, 12'h222);
        goto(9, 0); tick();
        check("t2_done_a", busy_a, 1'b0);
        goto(0, 0); tick();
        check("t2_new_a", rgb_a, 12'h222);

        // Request on the edge cycle is deferred a full frame.
        goto(9, 0); request(4); tick();
        check("t3_defer_busy_b", busy_b, 1'b1);
        check("t3_defer_cur_b", cur_b, 3'd2);
        set_pix(4, 12'h444);
        goto(9, 0); tick();
        check("t3_cur_b", cur_b, 3'd4);
        goto(9, 0); tick();

        // Latest request wins; out-of-range index ignored.
        goto(2, 0); request(1); tick();
        goto(3, 0); request(3); tick();
        goto(4, 0); request(5); tick();
        goto(9, 0); tick();
        check("t4_cur_a", cur_a, 3'd3);
        check("t4_cur_b", cur_b, 3'd3);
        goto(9, 0); tick();
        goto(9, 0); tick();
        check("t4_single_b", {cur_b, busy_b}, {3'd3, 1'b0});
        check("t4_single_a", {cur_a, busy_a}, {3'd3, 1'b0});

        // Overlay on source 1 over source 0.
        goto(2, 0); request(1); tick();
        goto(9, 0); tick();
        goto(9, 0); tick();
        goto(1, 2); set_pix(0, 12'h123); set_pix(1, 12'hF0F); ovl_en = 1'b1; tick();
        check("t5_ovl_on_a", rgb_a, 12'h123);
        check("t5_ovl_on_b", rgb_b, 12'h123);
        ovl_en = 1'b0; tick();
        check("t5_ovl_off_a", rgb_a, 12'hF0F);

        // Horizontal blanking forces black.
        set_pix(1, 12'hABC);
        goto(1, 11); tick();
        check("t6_active_a", rgb_a, 12'hABC);
        tick();
        check("t6_hblank_a", rgb_a, 12'h000);

        // Asynchronous reset mid-frame discards a pending request.
        goto(3, 5); tick();
        check("t7_pre_a", rgb_a, 12'hABC);
        request(2); tick();
        check("t7_busy_a", busy_a, 1'b1);
        rst = 1'b0;
        #2;
        check("t7_rst_a", {hs_a, vs_a, hb_a, vb_a, busy_a, cur_a, rgb_a}, 32'h0);
        check("t7_rst_b", {busy_b, cur_b, rgb_b}, 32'h0);
        tick(); tick();
        rst = 1'b1;
        goto(9, 0); tick();
        goto(9, 0); tick();
        check("t7_discard_a", {cur_a, busy_a}, 4'b0000);

        // Randomized traffic against the model.
        rand_pix = 1'b1;
        for (int c = 0; c < 40 * HTOT * VTOT; c++) begin
            tick();
            if ($urandom_range(0, 49) == 0) request(int'($urandom_range(0, 7)));
            if (hcnt == 0 && $urandom_range(0, 3) == 0) ovl_en = ~ovl_en;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
